// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ready handshake and
// computes the next PC from jump/branch controls when the datapath commits.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        commit,
  input  logic        Branch,
  input  logic        BranchNE,
  input  logic        Jump,
  input  logic        Zero,
  output logic        fetch_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t          state, state_nx;
  logic [31:0]     pc_nx, instr_nx, next_pc, jump_tgt, br_tgt;
  logic            valid_nx, err_nx, taken;
  logic [CW-1:0]   cnt, cnt_nx, cnt_inc;

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign pc_plus4  = pc + 32'd4;
  assign cnt_inc   = cnt + 1'b1;
  assign jump_tgt  = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign br_tgt    = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};

  // Controls only count when exactly 1; X/0 take the else path (sequential).
  always_comb begin
    taken = 1'b0;
    if (BranchNE == 1'b1) taken = (Zero == 1'b0);
    else                  taken = (Zero == 1'b1);
    next_pc = pc_plus4;
    if (Jump == 1'b1)                     next_pc = jump_tgt;
    else if ((Branch == 1'b1) && taken)   next_pc = br_tgt;
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = instr;
    valid_nx = instr_valid;
    err_nx   = fetch_err;
    cnt_nx   = cnt;
    case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        if (imem_ready == 1'b1) begin
          instr_nx = imem_rdata;
          valid_nx = 1'b1;
          cnt_nx   = '0;
          state_nx = EXEC;
        end else begin
          cnt_nx = cnt_inc;
          if ((TIMEOUT_CYCLES != 0) && (cnt_inc == CW'(TIMEOUT_CYCLES))) begin
            err_nx   = 1'b1;
            state_nx = HALT;
          end
        end
      end
      EXEC: begin
        // A stall wins over a simultaneous commit.
        if ((commit == 1'b1) && !(stall == 1'b1)) begin
          pc_nx    = next_pc;
          valid_nx = 1'b0;
          state_nx = FETCH;
        end
      end
      HALT: ;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      instr       <= instr_nx;
      instr_valid <= valid_nx;
      fetch_err   <= err_nx;
      cnt         <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, random instruction stream
// against a next-PC model, then timeout/HALT and asynchronous reset sequences.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req, imem_ready, instr_valid, fetch_err;
  logic        stall, commit, Branch, BranchNE, Jump, Zero;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4;
  logic [5:0]  opcode;

  int total = 0;
  int bad   = 0;
  logic [31:0] cur_pc;

  pc_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .opcode(opcode), .pc(pc), .pc_plus4(pc_plus4),
    .stall(stall), .commit(commit), .Branch(Branch), .BranchNE(BranchNE),
    .Jump(Jump), .Zero(Zero), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          dly;
    int          stl;
    logic        j, b, ne, z;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference next-PC from the architectural rules, plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                           input logic j, input logic b,
                                           input logic ne, input logic z);
    logic [31:0] p4;
    int off;
    p4 = p + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    if (b && (ne ? !z : z)) begin
      off = int'($signed(ins[15:0]));
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  task automatic run_instr(input logic [31:0] rd, input int dly, input int stl,
                           input logic j, input logic b, input logic ne, input logic z,
                           input logic [31:0] exp_nx);
    chk("fetch_req", {31'b0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, cur_pc);
    imem_ready = 1'b0;
    repeat (dly) tick();
    chk("valid_before_ready", {31'b0, instr_valid}, 32'd0);
    imem_ready = 1'b1;
    imem_rdata = rd;
    tick();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    chk("valid_latency", {31'b0, instr_valid}, 32'd1);
    chk("instr", instr, rd);
    chk("opcode", {26'b0, opcode}, {26'b0, rd[31:26]});
    chk("exec_req", {31'b0, imem_req}, 32'd0);
    chk("pc_plus4", pc_plus4, cur_pc + 32'd4);
    Jump = j; Branch = b; BranchNE = ne; Zero = z;
    commit = 1'b1;
    stall  = (stl > 0);
    for (int k = 0; k < stl; k++) begin
      imem_ready = 1'b1;
      tick();
      chk("stall_pc", pc, cur_pc);
      chk("stall_instr", instr, rd);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
    end
    imem_ready = 1'b0;
    stall = 1'b0;
    tick();
    commit = 1'b0; Jump = 1'b0; Branch = 1'b0; BranchNE = 1'b0; Zero = 1'b0;
    chk("next_pc", pc, exp_nx);
    chk("valid_after_commit", {31'b0, instr_valid}, 32'd0);
    cur_pc = exp_nx;
  endtask

  initial begin
    // rdata, ready-low cycles, stall cycles, J, B, BNE, Z, expected next pc
    tbl[0] = '{32'h1000_0003, 2,  0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0010};
    tbl[1] = '{32'h1000_0003, 0,  0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0014};
    tbl[2] = '{32'h1400_0003, 1,  0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0018};
    tbl[3] = '{32'h1400_0002, 0,  0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0024};
    tbl[4] = '{32'h0800_0040, 0,  0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100};
    tbl[5] = '{32'h1000_FFFF, 0,  0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100};
    tbl[6] = '{32'h1000_0005, 0,  3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0104};
    tbl[7] = '{32'h0800_0000, 15, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    tbl[8] = '{32'h1000_FFFE, 0,  1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC};

    reset_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    stall = 1'b0; commit = 1'b0; Branch = 1'b0; BranchNE = 1'b0; Jump = 1'b0; Zero = 1'b0;
    repeat (3) tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);
    reset_n = 1'b1;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    tick();
    cur_pc = 32'h0;

    foreach (tbl[i])
      run_instr(tbl[i].rdata, tbl[i].dly, tbl[i].stl, tbl[i].j, tbl[i].b,
                tbl[i].ne, tbl[i].z, tbl[i].exp_pc);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] rd;
      logic j, b, ne, z;
      rd = $urandom;
      j  = ($urandom_range(0, 3) == 0);
      b  = $urandom_range(0, 1);
      ne = $urandom_range(0, 1);
      z  = $urandom_range(0, 1);
      run_instr(rd, $urandom_range(0, 15), $urandom_range(0, 2), j, b, ne, z,
                ref_next(cur_pc, rd, j, b, ne, z));
    end

    // Fetch timeout: 16 edges with ready low
    imem_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) begin
        chk("to_err_early", {31'b0, fetch_err}, 32'd0);
        chk("to_req_early", {31'b0, imem_req}, 32'd1);
      end
    end
    chk("to_err", {31'b0, fetch_err}, 32'd1);
    chk("to_req", {31'b0, imem_req}, 32'd0);
    imem_ready = 1'b1; commit = 1'b1;
    repeat (4) tick();
    imem_ready = 1'b0; commit = 1'b0;
    chk("halt_req", {31'b0, imem_req}, 32'd0);
    chk("halt_valid", {31'b0, instr_valid}, 32'd0);
    chk("halt_pc", pc, cur_pc);
    chk("halt_err", {31'b0, fetch_err}, 32'd1);

    // Reset out of HALT, then a reset asserted mid-fetch
    reset_n = 1'b0;
    #1;
    chk("halt_rst_err", {31'b0, fetch_err}, 32'd0);
    chk("halt_rst_pc", pc, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("refetch_req", {31'b0, imem_req}, 32'd1);
    chk("refetch_addr", imem_addr, 32'h0);
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_err", {31'b0, fetch_err}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
